// File: rtl/c3_slice_arbiter.sv
// c3_slice_arbiter: shares one pipelined OR slice (e = c | d) among NREQ requesters, round-robin.
// Define C3_SLICE_ARB_FIXED_PRIO_EN to grant the lowest-index eligible requester instead.
module c3_slice_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_c,
  input  logic [NREQ-1:0]         req_d,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NREQ-1:0]         rsp_e,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0] r_pend;
  logic [NREQ-1:0] r_rsp_valid;
  logic [NREQ-1:0] r_rsp_e;
  logic [IDW-1:0]  r_grant_id;
  logic            r_busy;

  logic [NREQ-1:0] w_elig;
  logic [IDW-1:0]  w_base;
  logic [IDW-1:0]  w_idx;
  logic            w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_take;

  logic            w_fin_v;
  logic [IDW-1:0]  w_fin_id;
  logic            w_fin_e;

  logic [NREQ-1:0] w_rsp_hs;
  logic [NREQ-1:0] w_pend_nxt;
  logic [NREQ-1:0] w_rsp_valid_nxt;
  logic [NREQ-1:0] w_rsp_e_nxt;

  // A pending requester is never eligible, so its result slot is always free.
  assign w_elig = req_valid & ~r_pend;

`ifdef C3_SLICE_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDW-1:0] r_ptr;

  assign w_base = r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end
`endif

  // First eligible requester at or after the search base, wrapping modulo NREQ.
  always_comb begin : p_search
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IDW'((32'(w_base) + k) % NREQ);
      if (!w_gnt && w_elig[w_idx]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  assign w_take = rst_n & w_gnt;

  always_comb begin : p_ready
    req_ready = '0;
    if (w_take) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // PIPE_DEPTH-1 operand stages; the response register is the last stage.
  if (PIPE_DEPTH > 1) begin : g_pipe
    localparam int unsigned NST = PIPE_DEPTH - 1;

    logic [NST-1:0] r_sv;
    logic [NST-1:0] r_sc;
    logic [NST-1:0] r_sd;
    logic [IDW-1:0] r_sid [NST];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sv <= '0;
        r_sc <= '0;
        r_sd <= '0;
        for (int unsigned s = 0; s < NST; s++) begin
          r_sid[s] <= '0;
        end
      end else begin
        r_sv[0]  <= w_take;
        r_sid[0] <= w_gnt_idx;
        r_sc[0]  <= req_c[w_gnt_idx];
        r_sd[0]  <= req_d[w_gnt_idx];
        for (int unsigned s = 1; s < NST; s++) begin
          r_sv[s]  <= r_sv[s-1];
          r_sid[s] <= r_sid[s-1];
          r_sc[s]  <= r_sc[s-1];
          r_sd[s]  <= r_sd[s-1];
        end
      end
    end

    assign w_fin_v  = r_sv[NST-1];
    assign w_fin_id = r_sid[NST-1];
    assign w_fin_e  = r_sc[NST-1] | r_sd[NST-1];
  end else begin : g_direct
    assign w_fin_v  = w_take;
    assign w_fin_id = w_gnt_idx;
    assign w_fin_e  = req_c[w_gnt_idx] | req_d[w_gnt_idx];
  end

  // Response handshake frees the requester; new grants and arriving results mark slots.
  always_comb begin : p_next
    w_rsp_hs        = r_rsp_valid & rsp_ready;
    w_pend_nxt      = r_pend & ~w_rsp_hs;
    w_rsp_valid_nxt = r_rsp_valid & ~w_rsp_hs;
    w_rsp_e_nxt     = r_rsp_e;
    if (w_take) begin
      w_pend_nxt[w_gnt_idx] = 1'b1;
    end
    if (w_fin_v) begin
      w_rsp_valid_nxt[w_fin_id] = 1'b1;
      w_rsp_e_nxt[w_fin_id]     = w_fin_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_rsp_valid <= '0;
      r_rsp_e     <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_e     <= w_rsp_e_nxt;
      r_busy      <= |w_pend_nxt;
      if (w_take) begin
        r_grant_id <= w_gnt_idx;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_e     = r_rsp_e;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_no_pend_grant: assert property (@(posedge clk) disable iff (!rst_n) (req_ready & r_pend) == '0);
  a_rsp_implies_pend: assert property (@(posedge clk) disable iff (!rst_n) (r_rsp_valid & ~r_pend) == '0);

endmodule

// File: tb/tb_c3_slice_arbiter.sv
// Randomized scoreboard bench for c3_slice_arbiter against a cycle-level reference model.
`timescale 1ns/1ps
module tb_c3_slice_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned PD   = 3;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_c, req_d, req_ready;
  logic [NREQ-1:0] rsp_valid, rsp_e, rsp_ready;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  c3_slice_arbiter #(.NREQ(NREQ), .PIPE_DEPTH(PD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_c     (req_c),
    .req_d     (req_d),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_e     (rsp_e),
    .rsp_ready (rsp_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int due;
    int e;
  } exp_t;

  exp_t            sb[$];
  int              checks   = 0;
  int              failures = 0;
  int              cyc      = 0;
  bit              armed    = 1'b0;
  bit [NREQ-1:0]   mpend    = '0;
  int              mvis [NREQ];
  int              mptr     = 0;
  int              mgid     = 0;
  int              last_gnt = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    int base;
`ifdef C3_SLICE_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = mptr;
`endif
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (base + k) % int'(NREQ);
      if (v[idx] && !mpend[idx]) return idx;
    end
    return -1;
  endfunction

  // One cycle: check registered state, drive inputs, check grant, advance the model.
  task automatic do_cycle(input logic rn, input logic [NREQ-1:0] v, input logic [NREQ-1:0] c,
                          input logic [NREQ-1:0] d, input logic [NREQ-1:0] r);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    if (armed) begin
      chk("busy", int'(busy), int'(|mpend));
      chk("grant_id", int'(grant_id), mgid);
    end
    rst_n     = rn;
    req_valid = v;
    req_c     = c;
    req_d     = d;
    rsp_ready = r;
    #1;
    g       = rn ? pick(v) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    last_gnt = g;
    if (!rn) begin
      mpend = '0;
      mptr  = 0;
      mgid  = 0;
      sb.delete();
      armed = 1'b1;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (mpend[i] && cyc >= mvis[i] && r[i]) mpend[i] = 1'b0;
      end
      if (g >= 0) begin
        mpend[g] = 1'b1;
        mvis[g]  = cyc + int'(PD);
        mptr     = (g + 1) % int'(NREQ);
        mgid     = g;
        sb.push_back('{id: g, due: cyc + int'(PD), e: int'(c[g] | d[g])});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b1, '0, '0, '0, '1);
  endtask

  // Monitor: pops expected results as the DUT presents them, tracks hold/clear behaviour.
  initial begin : monitor
    bit [NREQ-1:0] mshown;
    int            me [NREQ];
    bit            exp_new;
    exp_t          x;
    mshown = '0;
    for (int i = 0; i < int'(NREQ); i++) me[i] = 0;
    wait (armed);
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!rst_n) begin
          chk("rsp_valid_reset", int'(rsp_valid[i]), 0);
          chk("rsp_e_reset", int'(rsp_e[i]), 0);
          mshown[i] = 1'b0;
          me[i]     = 0;
        end else if (mshown[i]) begin
          if (rsp_ready[i]) begin
            mshown[i] = 1'b0;
            chk("rsp_valid_cleared", int'(rsp_valid[i]), 0);
          end else begin
            chk("rsp_valid_held", int'(rsp_valid[i]), 1);
          end
          chk("rsp_e_held", int'(rsp_e[i]), me[i]);
        end else begin
          exp_new = (sb.size() > 0) && (sb[0].id == i) && (sb[0].due == cyc);
          chk("rsp_valid", int'(rsp_valid[i]), int'(exp_new));
          if (exp_new) begin
            x = sb.pop_front();
            chk("rsp_e", int'(rsp_e[i]), x.e);
            me[i]     = x.e;
            mshown[i] = 1'b1;
          end else begin
            chk("rsp_e_idle", int'(rsp_e[i]), me[i]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    req_valid = '0;
    req_c     = '0;
    req_d     = '0;
    rsp_ready = '0;

    // Reset with all requests raised: req_ready must stay low.
    repeat (3) do_cycle(1'b0, '1, '0, '0, '1);

    // Single request from requester 0.
    idle(5);
    do_cycle(1'b1, NREQ'(1), NREQ'(1), '0, '1);
    idle(6);

    // Full contention, all responses accepted.
    repeat (24) do_cycle(1'b1, '1, NREQ'($urandom), NREQ'($urandom), '1);

    // Backpressure on requester 1, then release.
    repeat (12) do_cycle(1'b1, '1, NREQ'($urandom), NREQ'($urandom), NREQ'(4'b1101));
    repeat (12) do_cycle(1'b1, '1, NREQ'($urandom), NREQ'($urandom), '1);
    idle(8);

    // OR truth table through requester 2.
    for (int k = 0; k < 4; k++) begin
      int              n;
      bit              got;
      logic [NREQ-1:0] cv, dv;
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        cv    = '0;
        dv    = '0;
        cv[2] = k[1];
        dv[2] = k[0];
        do_cycle(1'b1, NREQ'(4), cv, dv, '1);
        got = (last_gnt == 2);
        n++;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL truth_table_grant timeout k=%0d actual=no_grant expected=grant", k);
      end
    end
    idle(8);

    // Reset while requester 3 is in flight.
    do_cycle(1'b1, NREQ'(8), '1, '0, '1);
    do_cycle(1'b0, '0, '0, '0, '1);
    idle(10);
    do_cycle(1'b1, '1, NREQ'($urandom), NREQ'($urandom), '1);
    idle(8);

    // Random traffic with random backpressure and occasional reset.
    repeat (600) begin
      logic [NREQ-1:0] rv, rr;
      logic            rn;
      rv = NREQ'($urandom);
      rr = NREQ'($urandom | $urandom);
      rn = ($urandom_range(0, 99) != 0);
      do_cycle(rn, rv, NREQ'($urandom), NREQ'($urandom), rr);
    end

    idle(int'(PD) + 6);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c3_slice_arbiter.md
Name: c3_slice_arbiter

Overview:
- Shares one pipelined OR-evaluation slice among NREQ independent requesters.
- The slice is a registered c3→c4→c5→c6 style chain of PIPE_DEPTH stages computing e = c | d.
- Round-robin grant with a valid/ready handshake on both the request and response sides.
- Each requester may have at most one operation outstanding.
- Sits between lane controllers and the shared slice in the top-level datapath. It replaces per-lane slice instances.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- PIPE_DEPTH, 3, register stages in the shared slice; legal range 1..6. Equals grant-to-response latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester operation request.
- req_c  input  NREQ  operand c per requester.
- req_d  input  NREQ  operand d per requester.
- req_ready  output  NREQ  one-hot grant, combinational; handshake when req_valid[i] & req_ready[i].
- rsp_valid  output  NREQ  result available per requester.
- rsp_e  output  NREQ  result bit per requester.
- rsp_ready  input  NREQ  requester accepts its result.
- grant_id  output  $clog2(NREQ)  index of current grant; holds its last value when no grant.
- busy  output  1  OR of all pending flags.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Cleared: pend[], rsp_valid, rsp_e, pipeline valid bits, grant_id, RR pointer (→0).
  - In-flight operations are discarded; no response is ever produced for them.
  - req_ready is forced to 0 while rst_n is low.
- Eligibility: requester i is eligible when req_valid[i] & ~pend[i], using the registered pend only.
- Grant:
  - At most one grant per cycle.
  - Search starts at the RR pointer and wraps modulo NREQ; the first eligible requester wins.
  - req_ready is asserted only for the winner.
  - No eligible requester → req_ready = 0; pointer and grant_id hold.
- On grant to i (edge):
  - pend[i] ← 1.
  - Pointer ← (i+1) mod NREQ.
  - grant_id ← i.
  - Stage-1 register captures {valid=1, id=i, c=req_c[i], d=req_d[i]}.
- Pipeline:
  - Stages advance every cycle unconditionally; there is no stall.
  - Stalls are never needed because a pending requester cannot be re-granted, so its result slot is always free.
  - The final stage computes c|d.
- Response:
  - Grant in cycle N → on the edge ending cycle N+PIPE_DEPTH−1, rsp_valid[id] ← 1 and rsp_e[id] ← c|d.
  - rsp_valid[id] is visible in cycle N+PIPE_DEPTH.
- Response hold: rsp_valid[i] and rsp_e[i] stay stable until rsp_valid[i] & rsp_ready[i].
- Response handshake, on that edge:
  - rsp_valid[i] ← 0 and pend[i] ← 0.
  - rsp_e[i] holds its last value.
- Simultaneous handshake and request by the same requester: pend is cleared at the edge, so the earliest re-grant is the following cycle.
  - In steady state with all ready, each requester issues once every PIPE_DEPTH+1 cycles, or once every NREQ cycles, whichever is slower.
- rsp_ready[i] while rsp_valid[i] = 0: ignored.
- req_valid dropped before grant: permitted; no state change.
- busy = |pend, registered.
- grant_id width is $clog2(NREQ), minimum 1.

Optional Feature:
- Macro: C3_SLICE_ARB_FIXED_PRIO_EN.
- Defined:
  - Grant goes to the lowest-index eligible requester every cycle.
  - The RR pointer is not implemented; grant_id still updates.
- Undefined: round-robin as specified above. This is the default.

Test Plan:
- Single request, round-robin:
  - Stimulus: reset released; cycle 5: req_valid=4'b0001, req_c[0]=1, req_d[0]=0; rsp_ready=4'b1111.
  - Response: req_ready=4'b0001 in cycle 5; rsp_valid[0]=1, rsp_e[0]=1 in cycle 8; busy=1 in cycles 6–8, busy=0 in cycle 9.
- Full contention, round-robin, rsp_ready all 1:
  - Stimulus: req_valid=4'b1111 held.
  - Response: grant order 0,1,2,3,0,1,… one per cycle; requester 0 is granted in cycles 0, 4 and 8.
- Backpressure:
  - Stimulus: as the previous test, but rsp_ready[1]=0 for 12 cycles.
  - Response: rsp_valid[1] and rsp_e[1] stay stable; requester 1 gets no second grant; 0, 2 and 3 keep rotating; requester 1 is granted again the cycle after rsp_ready[1] rises.
- Truth table:
  - Stimulus: requester 2 issues (c,d) = 00, 01, 10, 11.
  - Response: rsp_e[2] = 0, 1, 1, 1, each exactly PIPE_DEPTH cycles after its grant.
- Reset mid-flight:
  - Stimulus: grant to requester 3 in cycle 0; rst_n=0 in cycle 1 for 1 cycle.
  - Response: rsp_valid stays 0 for 10 cycles; busy=0; the next all-valid grant goes to requester 0.
- C3_SLICE_ARB_FIXED_PRIO_EN defined:
  - Stimulus: req_valid=4'b1111 with the default PIPE_DEPTH.
  - Response: requester 0 is granted in cycles 0 and 4; requesters 1, 2 and 3 are granted only in cycles when requester 0 is pending.
